// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduling path.
// Optional source-tag display is enabled in the top by defining SEG_SRC_TAG_EN.
package seg_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_CONVERT = 3'd3,
        ST_COMMIT  = 3'd4
    } seg_state_e;

    typedef logic [3:0] bcd_digit_t;

    // Three committed digits, most significant first (x.xx)
    typedef struct packed {
        bcd_digit_t int_d;
        bcd_digit_t frac1_d;
        bcd_digit_t frac2_d;
    } bcd3_t;

    localparam int unsigned MAX_DISPLAY = 999;
    localparam int unsigned BCD_W       = 12;
    localparam bcd_digit_t  TAG_BASE    = 4'hA;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int n = 0; n < int'(BCD_W / 4); n++) begin
            if (r[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, DATA_W cycles per
// conversion into a 12-bit BCD accumulator. o_done_c flags the final step.
module seg_bin2bcd_seq
    import seg_disp_pkg::*;
#(
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_bin,
    output logic              o_busy,
    output logic              o_done_c,
    output logic [BCD_W-1:0]  o_bcd
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [BCD_W-1:0]  w_adj;

    assign w_adj = bcd_add3(r_bcd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= CNT_W'(DATA_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done_c = r_busy && (r_cnt == CNT_W'(1));
    assign o_bcd    = r_bcd;

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler feeding one measurement sample per hold period to the
// 3-digit display. Define SEG_SRC_TAG_EN to show a source tag (A/b/C) first.
module seg_display_scheduler
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned HOLD_CYCLES = 6000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      freeze,
    output logic [3:0]                int_digit,
    output logic [3:0]                frac1_digit,
    output logic [3:0]                frac2_digit,
    output logic [2:0]                cur_src,
    output logic                      overrange,
    output logic                      update
);

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned TMR_W   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DATA8_W = 8 * DATA_W;
    localparam int unsigned CMP_W   = (DATA_W > 10) ? DATA_W : 10;

    seg_state_e         r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [SEL_W-1:0]   r_rr;
    logic [SEL_W-1:0]   r_grant;
    logic               r_over_pend;
    logic [NUM_SRC-1:0] r_ready;
    bcd3_t              r_disp;
    logic [SEL_W-1:0]   r_cur_src;
    logic               r_over;
    logic               r_update;

    logic               w_hit;
    logic [SEL_W-1:0]   w_pick;
    int unsigned        w_best;
    int unsigned        w_dist;
    logic [7:0]         w_valid8;
    logic [DATA8_W-1:0] w_data8;
    logic [DATA_W-1:0]  w_samples [8];
    logic [DATA_W-1:0]  w_sel_sample;
    logic               w_over;
    logic [DATA_W-1:0]  w_clamped;
    logic               w_start;
    logic               w_busy;
    logic               w_done_c;
    logic [BCD_W-1:0]   w_bcd;

    // Sources widened to 8 so a 3-bit grant indexes them without range issues
    assign w_valid8 = 8'(src_valid);
    assign w_data8  = DATA8_W'(src_data);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_samples[i] = w_data8[i*DATA_W +: DATA_W];
        end
    end

    // Nearest valid source after the last served one, wrapping modulo NUM_SRC
    always_comb begin
        w_hit  = 1'b0;
        w_pick = '0;
        w_best = NUM_SRC;
        w_dist = 0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            w_dist = (i + 2 * NUM_SRC - 1 - int'(r_rr)) % NUM_SRC;
            if (src_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_hit  = 1'b1;
                w_pick = SEL_W'(i);
            end
        end
    end

    assign w_sel_sample = w_samples[r_grant];
    assign w_over       = CMP_W'(w_sel_sample) > CMP_W'(MAX_DISPLAY);
    assign w_clamped    = w_over ? DATA_W'(MAX_DISPLAY) : w_sel_sample;
    assign w_start      = (r_state == ST_CAPTURE) && w_valid8[r_grant];

    seg_bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_bin    (w_clamped),
        .o_busy   (w_busy),
        .o_done_c (w_done_c),
        .o_bcd    (w_bcd)
    );

`ifdef SEG_SRC_TAG_EN
    localparam int unsigned QUARTER = (HOLD_CYCLES >= 8) ? HOLD_CYCLES / 4 : 1;
    logic [3:0] r_int_out;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_rr        <= SEL_W'(NUM_SRC - 1);
            r_grant     <= '0;
            r_over_pend <= 1'b0;
            r_ready     <= '0;
            r_disp      <= '0;
            r_cur_src   <= '0;
            r_over      <= 1'b0;
            r_update    <= 1'b0;
`ifdef SEG_SRC_TAG_EN
            r_int_out   <= '0;
`endif
        end else begin
            r_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!freeze) begin
                        if (r_timer == TMR_W'(HOLD_CYCLES - 1)) begin
                            r_timer <= '0;
                            r_state <= ST_SELECT;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
`ifdef SEG_SRC_TAG_EN
                        if (r_timer == TMR_W'(QUARTER - 1)) begin
                            r_int_out <= r_disp.int_d;
                        end
`endif
                    end
                end
                ST_SELECT: begin
                    if (w_hit) begin
                        r_grant <= w_pick;
                        r_ready <= NUM_SRC'(1) << w_pick;
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    r_ready <= '0;
                    if (w_valid8[r_grant]) begin
                        r_rr        <= r_grant;
                        r_over_pend <= w_over;
                        r_state     <= ST_CONVERT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    // An idle engine here can only mean a lost start; drop the sample
                    if (w_done_c) begin
                        r_state <= ST_COMMIT;
                    end else if (!w_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    r_disp    <= w_bcd;
                    r_cur_src <= r_grant;
                    r_over    <= r_over_pend;
                    r_update  <= 1'b1;
                    r_state   <= ST_IDLE;
`ifdef SEG_SRC_TAG_EN
                    r_int_out <= TAG_BASE + 4'(r_grant);
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign src_ready   = r_ready;
`ifdef SEG_SRC_TAG_EN
    assign int_digit   = r_int_out;
`else
    assign int_digit   = r_disp.int_d;
`endif
    assign frac1_digit = r_disp.frac1_d;
    assign frac2_digit = r_disp.frac2_d;
    assign cur_src     = r_cur_src;
    assign overrange   = r_over;
    assign update      = r_update;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with a cycle-level reference model
// built from the tick/latency/rotation rules, checked on every cycle.
module tb_seg_display_scheduler;

    localparam int NS  = 3;
    localparam int DW  = 10;
    localparam int H   = 40;
    localparam int LAT = DW + 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              freeze = 1'b0;
    logic [NS-1:0]     src_valid = '0;
    logic [NS*DW-1:0]  src_data = '0;
    logic [NS-1:0]     src_ready;
    logic [3:0]        int_digit, frac1_digit, frac2_digit;
    logic [2:0]        cur_src;
    logic              overrange, update;

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .NUM_SRC     (NS),
        .DATA_W      (DW),
        .HOLD_CYCLES (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .freeze      (freeze),
        .int_digit   (int_digit),
        .frac1_digit (frac1_digit),
        .frac2_digit (frac2_digit),
        .cur_src     (cur_src),
        .overrange   (overrange),
        .update      (update)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase counted from the timer tick; events at fixed offsets
    bit m_init = 0;
    int m_idle, m_since, m_pick, m_rr, m_v;
    int p_int, p_f1, p_f2, p_over;
    int e_int, e_f1, e_f2, e_src, e_over, e_upd, e_ready;

    always @(posedge clk) begin
        e_upd = 0;
        if (!rst_n) begin
            m_init = 1; m_idle = 0; m_since = -1; m_rr = NS - 1;
            e_int = 0; e_f1 = 0; e_f2 = 0; e_src = 0; e_over = 0; e_ready = 0;
        end else if (m_since < 0) begin
            if (!freeze) begin
                if (m_idle == H - 1) begin
                    m_idle = 0;
                    m_since = 0;
                end else begin
                    m_idle++;
                end
            end
        end else begin
            m_since++;
            if (m_since == 1) begin
                m_pick = -1;
                for (int k = 1; k <= NS; k++)
                    if (m_pick < 0 && src_valid[(m_rr + k) % NS]) m_pick = (m_rr + k) % NS;
                if (m_pick < 0) m_since = -1;
                else e_ready = 1 << m_pick;
            end else if (m_since == 2) begin
                e_ready = 0;
                if (src_valid[m_pick]) begin
                    m_rr = m_pick;
                    m_v = int'(src_data[m_pick*DW +: DW]);
                    p_over = (m_v > 999) ? 1 : 0;
                    if (m_v > 999) m_v = 999;
                    p_int = m_v / 100;
                    p_f1 = (m_v / 10) % 10;
                    p_f2 = m_v % 10;
                end else begin
                    m_since = -1;
                end
            end else if (m_since == LAT) begin
                e_int = p_int; e_f1 = p_f1; e_f2 = p_f2; e_over = p_over;
                e_src = m_rr; e_upd = 1; m_since = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("update",    32'(update),      32'(e_upd));
            chk("src_ready", 32'(src_ready),   32'(e_ready));
            chk("int_digit", 32'(int_digit),   32'(e_int));
            chk("frac1",     32'(frac1_digit), 32'(e_f1));
            chk("frac2",     32'(frac2_digit), 32'(e_f2));
            chk("cur_src",   32'(cur_src),     32'(e_src));
            chk("overrange", 32'(overrange),   32'(e_over));
        end
    end

    task automatic wait_upd(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (update === 1'b1) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL upd_timeout: no update within %0d cycles", budget);
    endtask

    task automatic count_pulses(input int n, output int upd_n, output int rdy_n);
        upd_n = 0;
        rdy_n = 0;
        repeat (n) begin
            @(negedge clk);
            if (update === 1'b1) upd_n++;
            if (src_ready !== '0) rdy_n++;
        end
    endtask

    task automatic expect_disp(input string nm, input int s, input int d2, input int d1,
                               input int d0, input int ov);
        chk({nm, "_src"},  32'(cur_src),     32'(s));
        chk({nm, "_int"},  32'(int_digit),   32'(d2));
        chk({nm, "_f1"},   32'(frac1_digit), 32'(d1));
        chk({nm, "_f2"},   32'(frac2_digit), 32'(d0));
        chk({nm, "_ovr"},  32'(overrange),   32'(ov));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expect_disp("rst", 0, 0, 0, 0, 0);
        chk("rst_upd", 32'(update), 32'd0);
        chk("rst_rdy", 32'(src_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc, un, rn;

        // Single source, first update exactly HOLD_CYCLES + latency after reset
        src_valid = 3'b001;
        src_data[0 +: DW] = 10'd345;
        do_reset();
        wait_upd(H + LAT + 10, cyc);
        chk("first_latency", 32'(cyc), 32'(H + LAT));
        expect_disp("d345", 0, 3, 4, 5, 0);

        // All valid: strict rotation 0,1,2,0
        src_data[0*DW +: DW] = 10'd100;
        src_data[1*DW +: DW] = 10'd250;
        src_data[2*DW +: DW] = 10'd999;
        src_valid = 3'b111;
        do_reset();
        wait_upd(H + LAT + 10, cyc); expect_disp("rr0", 0, 1, 0, 0, 0);
        wait_upd(H + LAT + 10, cyc); expect_disp("rr1", 1, 2, 5, 0, 0);
        wait_upd(H + LAT + 10, cyc); expect_disp("rr2", 2, 9, 9, 9, 0);
        wait_upd(H + LAT + 10, cyc); expect_disp("rr3", 0, 1, 0, 0, 0);

        // Saturation then recovery
        src_valid = 3'b001;
        src_data[0 +: DW] = 10'd1023;
        wait_upd(H + LAT + 10, cyc); expect_disp("sat", 0, 9, 9, 9, 1);
        src_data[0 +: DW] = 10'd5;
        wait_upd(H + LAT + 10, cyc); expect_disp("small", 0, 0, 0, 5, 0);

        // Nothing valid at the tick: no grant, no update, digits held
        src_valid = '0;
        count_pulses(H + 20, un, rn);
        chk("idle_upd_cnt", 32'(un), 32'd0);
        chk("idle_rdy_cnt", 32'(rn), 32'd0);
        expect_disp("held", 0, 0, 0, 5, 0);
        src_data[1*DW +: DW] = 10'd777;
        src_valid = 3'b010;
        wait_upd(2 * H + LAT + 10, cyc); expect_disp("late", 1, 7, 7, 7, 0);

        // Freeze after 15 idle cycles, resume finishes the remaining count
        repeat (15) @(negedge clk);
        freeze = 1'b1;
        count_pulses(3 * H, un, rn);
        chk("frz_upd_cnt", 32'(un), 32'd0);
        freeze = 1'b0;
        wait_upd(H + LAT + 10, cyc);
        chk("freeze_resume", 32'(cyc), 32'(H - 15 + LAT));

        // Reset in the middle of a conversion
        cyc = 0;
        while (src_ready === '0 && cyc < 2 * H + LAT) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant_seen", 32'(src_ready), 32'b010);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        expect_disp("mid_rst", 0, 0, 0, 0, 0);
        chk("mid_rst_rdy", 32'(src_ready), 32'd0);
        rst_n = 1'b1;
        count_pulses(LAT + 5, un, rn);
        chk("mid_rst_upd", 32'(un), 32'd0);
        wait_upd(H + LAT + 10, cyc); expect_disp("post_rst", 1, 7, 7, 7, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
Sequences the three-digit seven-segment display path (integer digit, two fractional digits) between several measurement sources: voltage, Vpp and frequency.
- Round-robin grants one source per display period.
- Captures its binary sample via a valid/ready handshake.
- Converts it to BCD with a sequential double-dabble engine.
- Commits the three digits to the segment displayer's digit inputs.
Sits between the measurement datapaths and the segment displayer; owns display refresh timing.

Parameters:
NUM_SRC, 3, number of requesting sources (2..8)
DATA_W, 10, binary sample width; value v represents v/100 (x.xx)
HOLD_CYCLES, 6000000, clk cycles each value stays on display (0.5 s at 12 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
src_valid  input  NUM_SRC  per-source sample valid
src_data  input  NUM_SRC*DATA_W  packed samples, source i at [i*DATA_W +: DATA_W]
src_ready  output  NUM_SRC  one-hot grant/accept, high exactly in CAPTURE for granted source
freeze  input  1  high: timer paused, display held, no new grants
int_digit  output  4  BCD integer digit
frac1_digit  output  4  BCD first fractional digit
frac2_digit  output  4  BCD second fractional digit
cur_src  output  3  index of source currently displayed
overrange  output  1  displayed sample exceeded 999 (saturated)
update  output  1  one-cycle pulse when digits change

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, timer=0, rr pointer=NUM_SRC-1, all digits 0, cur_src=0, overrange=0, update=0, src_ready=0.
- Mid-operation reset aborts any conversion; no partial digits are committed.
- Timer: increments in IDLE when freeze=0. At HOLD_CYCLES-1 it wraps to 0 and raises internal tick. First tick occurs HOLD_CYCLES cycles after reset.
- FSM states: IDLE, SELECT, CAPTURE, CONVERT, COMMIT.
  - IDLE -> SELECT on tick.
  - SELECT, one cycle: search src_valid starting at rr+1 modulo NUM_SRC.
    - Hit: grant that index, -> CAPTURE.
    - No valid source: -> IDLE; digits unchanged, no update pulse, next attempt on next tick.
  - CAPTURE: src_ready[grant]=1 for one cycle. Sample latched only if src_valid[grant] is still 1; rr<=grant; -> CONVERT. If valid dropped, -> IDLE with no change.
  - CONVERT: DATA_W cycles of shift-add-3 double dabble on a 12-bit BCD accumulator. Sample >999 is clamped to 999 before conversion and overrange latched 1, else 0.
  - COMMIT: one cycle. Digits, cur_src and overrange registered together, update=1, -> IDLE.
- Latency from tick to update: 1 + 1 + DATA_W + 1 = DATA_W+3 cycles (13 at default).
- freeze=1: timer holds its value. Ticks are suppressed. An in-flight conversion completes and commits.
- Simultaneous valid from all sources: strict rotation 0,1,2,0,... with no source granted twice while another valid source waits.
- Outputs stable between update pulses. Segment displayer samples them asynchronously to its own multiplexing.

Optional Feature:
Macro SEG_SRC_TAG_EN.
- Defined: int_digit carries source tag 0xA+cur_src (A/b/C) during the first quarter of each hold period, then the integer digit. Displayer already decodes A–F.
- Undefined: int_digit always carries the integer digit; no tag logic synthesized.

Decomposition:
Shared package seg_disp_pkg:
- FSM state enum
- BCD digit typedef (4-bit)
- constant MAX_DISPLAY=999
- tag base 4'hA

One sub-module, seg_bin2bcd_seq:
- Ports: start/busy/done, DATA_W-bit in, 12-bit BCD out.
- Reused by the frequency readout later.

Test Plan:
- Reset then src_valid=3'b001, src_data[0]=10'd345 -> after HOLD_CYCLES+13 cycles: update pulse, digits 3/4/5, cur_src=0, overrange=0.
- All three valid with data 100, 250, 999 -> successive updates show 1.00, 2.50, 9.99 with cur_src 0,1,2, then 0 again.
- src_data=10'd1023 -> digits 9/9/9, overrange=1; next sample 5 -> digits 0/0/5, overrange=0.
- No source valid at tick -> no src_ready, no update, digits unchanged; valid asserted later is served at the next tick.
- freeze=1 for 3*HOLD_CYCLES -> no update pulses; release freeze -> next update HOLD_CYCLES minus elapsed count later.
- rst_n=0 during CONVERT -> all outputs zero next cycle, no update pulse; with SEG_SRC_TAG_EN defined, int_digit=0xA for the first quarter period after update on source 0.
